// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path definitions used by the PC, fetch queue and decode stages.
// Widths and enable levels match the legacy defines used by pc_reg/id.
package inst_fetch_queue_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int unsigned INST_ADDR_BUS_W = 32;
    localparam int unsigned INST_BUS_W      = 32;
    localparam int unsigned INST_BYTES      = 4;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

    typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;
    typedef logic [INST_BUS_W-1:0]      inst_t;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} entries.
// Clear empties the queue in one edge; a push in the same cycle is dropped.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i && (rst != RST_ENABLE)) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues ROM reads against queue
// credit, buffers returned words with their PCs and presents them to ID.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = INST_ADDR_BUS_W,
    parameter int unsigned       DATA_W   = INST_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        req_pc_q, req_pc_d;
    logic                     inflight_q, inflight_d;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CNT_W:0]           credit_used;
    logic                     in_reset, issue, push, pop, head_valid;

    always_comb begin
        in_reset    = (rst == RST_ENABLE);
        // Credit counts the in-flight word so a full queue never sees a response.
        credit_used = {1'b0, count} + (CNT_W+1)'(inflight_q);
        issue       = !in_reset && !flush_i && (credit_used < (CNT_W+1)'(DEPTH));
        // A response landing during a flush belongs to the abandoned stream.
        push        = inflight_q && !flush_i && !in_reset;
        head_valid  = !in_reset && (count != '0);
        pop         = head_valid && !stall_i && !flush_i;

        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = issue;
        if (flush_i) begin
            fetch_pc_d = new_pc_i & ~ADDR_W'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
            req_pc_d   = fetch_pc_q;
        end

        rom_ce_o   = issue ? CHIP_ENABLE : CHIP_DISABLE;
        rom_addr_o = in_reset ? RESET_PC : fetch_pc_q;
        id_valid_o = head_valid;
        id_pc_o    = head_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
        id_inst_o  = head_valid ? head[DATA_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({req_pc_q, rom_data_i}),
        .pop_i       (pop),
        .clear_i     (flush_i),
        .count_o     (count),
        .head_o      (head)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue; ROM model returns addr ^ 32'hA5A50000.
module tb_inst_fetch_queue;

    localparam logic [31:0] K = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic [31:0] rom_data_i = '0;
    logic [31:0] rom_addr_o, id_pc_o, id_inst_o;
    logic        rom_ce_o, id_valid_o;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_data_i (rom_data_i),
        .rom_addr_o (rom_addr_o),
        .rom_ce_o   (rom_ce_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .new_pc_i   (new_pc_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_ce_o) rom_data_i <= rom_addr_o ^ K;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One reset cycle; returns in the first cycle after reset is released.
    task automatic do_reset();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic        ev [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ep [4] = '{32'h0, 32'h0, 32'h4, 32'h8};
        logic [31:0] ei;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b exp 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", rom_addr_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", id_valid_o); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", id_pc_o); end
        checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h exp 0", id_inst_o); end
        rst = 1'b0;
        #1;
        checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin
            errors++; $display("FAIL first_issue: got ce=%b addr=%h exp ce=1 addr=0", rom_ce_o, rom_addr_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL first_valid: got %b exp 0", id_valid_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            ei = ev[i] ? (ep[i] ^ K) : 32'h0;
            checks++;
            if (id_valid_o !== ev[i] || id_pc_o !== (ev[i] ? ep[i] : 32'h0) || id_inst_o !== ei) begin
                errors++;
                $display("FAIL reset_stream[%0d]: got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, ev[i], ev[i] ? ep[i] : 32'h0, ei);
            end
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        stall_i = 1'b1;
        repeat (6) tick();
        checks++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h10) begin
            errors++; $display("FAIL full_hold: got ce=%b addr=%h exp ce=0 addr=10", rom_ce_o, rom_addr_o); end
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
            errors++; $display("FAIL full_head: got v=%b pc=%h exp v=1 pc=0", id_valid_o, id_pc_o); end
        stall_i = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * i) || id_inst_o !== (32'(4 * i) ^ K)) begin
                errors++;
                $display("FAIL drain[%0d]: got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, 32'(4 * i), 32'(4 * i) ^ K);
            end
            tick();
        end
    endtask

    task automatic test_flush_inflight();
        logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ep [4] = '{32'h0, 32'h0, 32'h200, 32'h204};
        logic [31:0] ei;
        do_reset();
        repeat (4) tick();
        flush_i = 1'b1; new_pc_i = 32'h200;
        #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL flush_ce: got %b exp 0", rom_ce_o); end
        tick();
        flush_i = 1'b0;
        #1;
        checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h200) begin
            errors++; $display("FAIL flush_redirect: got ce=%b addr=%h exp ce=1 addr=200", rom_ce_o, rom_addr_o); end
        for (int i = 0; i < 4; i++) begin
            ei = ev[i] ? (ep[i] ^ K) : 32'h0;
            checks++;
            if (id_valid_o !== ev[i] || id_pc_o !== ep[i] || id_inst_o !== ei) begin
                errors++;
                $display("FAIL flush_stream[%0d]: got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, ev[i], ep[i], ei);
            end
            tick();
        end
    endtask

    task automatic test_flush_stall_full();
        logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ep [4] = '{32'h0, 32'h0, 32'h40, 32'h44};
        logic [31:0] ei;
        do_reset();
        stall_i = 1'b1;
        repeat (6) tick();
        flush_i = 1'b1; new_pc_i = 32'h40;
        #1;
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL fs_ce: got %b exp 0", rom_ce_o); end
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            ei = ev[i] ? (ep[i] ^ K) : 32'h0;
            checks++;
            if (id_valid_o !== ev[i] || id_pc_o !== ep[i] || id_inst_o !== ei) begin
                errors++;
                $display("FAIL flush_stall[%0d]: got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, ev[i], ep[i], ei);
            end
            tick();
        end
    endtask

    task automatic test_wrap_align();
        logic [31:0] ep [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
        do_reset();
        repeat (3) tick();
        flush_i = 1'b1; new_pc_i = 32'hFFFFFFF8;
        tick();
        flush_i = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== ep[i] || id_inst_o !== (ep[i] ^ K)) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, ep[i], ep[i] ^ K);
            end
            tick();
        end
        flush_i = 1'b1; new_pc_i = 32'h00000103;
        tick();
        flush_i = 1'b0;
        #1;
        checks++; if (rom_addr_o !== 32'h100) begin errors++; $display("FAIL align_addr: got %h exp 100", rom_addr_o); end
        repeat (2) tick();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100) begin
            errors++; $display("FAIL align_pc: got v=%b pc=%h exp v=1 pc=100", id_valid_o, id_pc_o); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        stall_i = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        checks++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0) begin
            errors++; $display("FAIL mid_rst: got ce=%b addr=%h v=%b pc=%h exp ce=0 addr=0 v=0 pc=0",
                               rom_ce_o, rom_addr_o, id_valid_o, id_pc_o); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0 || rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin
            errors++; $display("FAIL post_rst: got v=%b ce=%b addr=%h exp v=0 ce=1 addr=0",
                               id_valid_o, rom_ce_o, rom_addr_o); end
        tick();
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_gap: got v=%b exp 0", id_valid_o); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== K) begin
            errors++; $display("FAIL refetch: got v=%b pc=%h inst=%h exp v=1 pc=0 inst=%h",
                               id_valid_o, id_pc_o, id_inst_o, K); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
            errors++; $display("FAIL refetch_hold: got v=%b pc=%h exp v=1 pc=0", id_valid_o, id_pc_o); end
        stall_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall_fill();
        test_flush_inflight();
        test_flush_stall_full();
        test_wrap_align();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
